// File: rtl/peripheral_burst_master_wb_pkg.sv
// Shared Wishbone B3 definitions for the burst master: FSM states, cycle-type
// and burst-type encodings, and the per-beat CTI selection.
package peripheral_burst_master_wb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      BUS,
      STALL,
      RETRY,
      DONE
   } state_t;

   localparam logic [2:0] CTI_CLASSIC      = 3'b000;
   localparam logic [2:0] CTI_INC_BURST    = 3'b010;
   localparam logic [2:0] CTI_END_OF_BURST = 3'b111;
   localparam logic [1:0] BTE_LINEAR       = 2'b00;

   // A single-beat command is a classic cycle; bursts flag their final beat.
   function automatic logic [2:0] cti_for_beat(input int unsigned beat, input int unsigned len);
      if (len == 0)
         return CTI_CLASSIC;
      else if (beat == len)
         return CTI_END_OF_BURST;
      else
         return CTI_INC_BURST;
   endfunction

endpackage

// File: rtl/peripheral_burst_master_wb.sv
// Wishbone B3 burst master: turns one command into an incrementing burst of
// up to MAX_BURST beats, with write-data stalling, retry and error abort.
module peripheral_burst_master_wb
   import peripheral_burst_master_wb_pkg::*;
#(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BURST = 16,
   localparam int LW       = $clog2(MAX_BURST)
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            cmd_valid_i,
   output logic            cmd_ready_o,
   input  logic [AW-1:0]   cmd_adr_i,
   input  logic            cmd_we_i,
   input  logic [LW-1:0]   cmd_len_i,
   input  logic            wdat_valid_i,
   input  logic [DW-1:0]   wdat_i,
   output logic            wdat_ready_o,
   output logic            rdat_valid_o,
   output logic [DW-1:0]   rdat_o,
   output logic            done_o,
   output logic            err_o,
   output logic [AW-1:0]   wb_adr_o,
   output logic [DW-1:0]   wb_dat_o,
   output logic [DW/8-1:0] wb_sel_o,
   output logic            wb_we_o,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   output logic [2:0]      wb_cti_o,
   output logic [1:0]      wb_bte_o,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic            wb_ack_i,
   input  logic            wb_err_i,
   input  logic            wb_rty_i
);

   localparam logic [AW-1:0] ADR_STEP = AW'(DW / 8);

   state_t        r_state;
   state_t        w_state_next;
   logic [AW-1:0] r_adr;
   logic          r_we;
   logic [LW-1:0] r_len;
   logic [LW-1:0] r_cnt;
   logic [DW-1:0] r_wdat;
   logic [DW-1:0] r_rdat;
   logic          r_rdat_valid;
   logic          r_err;

   logic          w_cyc;
   logic          w_stb;
   logic          w_ack;
   logic          w_err;
   logic          w_rty;
   logic          w_last;
   logic          w_accept;
   logic          w_load_wdat;

   assign w_cyc  = (r_state == BUS) || (r_state == STALL);
   assign w_stb  = (r_state == BUS);
   // Responses only count while strobing; err outranks rty, rty outranks ack.
   assign w_err  = w_stb & wb_err_i;
   assign w_rty  = w_stb & wb_rty_i & ~wb_err_i;
   assign w_ack  = w_stb & wb_ack_i & ~wb_err_i & ~wb_rty_i;
   assign w_last = (r_cnt == r_len);

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_load_wdat  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (cmd_valid_i) begin
               w_accept = 1'b1;
               if (cmd_we_i && !wdat_valid_i) begin
                  w_state_next = STALL;
               end else begin
                  w_state_next = BUS;
                  w_load_wdat  = cmd_we_i;
               end
            end
         end
         BUS: begin
            if (w_err)
               w_state_next = DONE;
            else if (w_rty)
               w_state_next = RETRY;
            else if (w_ack) begin
               // The next write word only becomes visible after this pop, so
               // write beats pass through STALL to register it.
               if (w_last)
                  w_state_next = DONE;
               else if (r_we)
                  w_state_next = STALL;
            end
         end
         STALL: begin
            if (wdat_valid_i) begin
               w_state_next = BUS;
               w_load_wdat  = 1'b1;
            end
         end
         RETRY:   w_state_next = BUS;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         r_adr        <= '0;
         r_we         <= 1'b0;
         r_len        <= '0;
         r_cnt        <= '0;
         r_wdat       <= '0;
         r_rdat       <= '0;
         r_rdat_valid <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_rdat_valid <= w_ack & ~r_we;
         if (w_ack && !r_we)
            r_rdat <= wb_dat_i;
         if (w_accept) begin
            r_adr <= cmd_adr_i;
            r_we  <= cmd_we_i;
            r_len <= cmd_len_i;
            r_cnt <= '0;
            r_err <= 1'b0;
         end else if (w_ack) begin
            r_adr <= r_adr + ADR_STEP;
            r_cnt <= r_cnt + LW'(1);
         end
         if (w_err)
            r_err <= 1'b1;
         if (w_load_wdat)
            r_wdat <= wdat_i;
      end
   end

   assign cmd_ready_o  = (r_state == IDLE);
   assign wdat_ready_o = w_ack & r_we;
   assign rdat_valid_o = r_rdat_valid;
   assign rdat_o       = r_rdat;
   assign done_o       = (r_state == DONE);
   assign err_o        = (r_state == DONE) & r_err;

   assign wb_adr_o = r_adr;
   assign wb_dat_o = r_wdat;
   assign wb_sel_o = {(DW / 8){w_cyc}};
   assign wb_we_o  = r_we & w_cyc;
   assign wb_cyc_o = w_cyc;
   assign wb_stb_o = w_stb;
   assign wb_cti_o = w_cyc ? cti_for_beat(32'(r_cnt), 32'(r_len)) : CTI_CLASSIC;
   assign wb_bte_o = BTE_LINEAR;

endmodule

// File: tb/tb_peripheral_burst_master_wb.sv
// Directed bench for the Wishbone burst master: a small memory slave with
// optional random read latency, out-of-range errors and one-shot retries.
module tb_peripheral_burst_master_wb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [31:0] cmd_adr_i;
   logic        cmd_we_i;
   logic [3:0]  cmd_len_i;
   logic        wdat_valid_i;
   logic [31:0] wdat_i;
   logic        wdat_ready_o;
   logic        rdat_valid_o;
   logic [31:0] rdat_o;
   logic        done_o;
   logic        err_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic [2:0]  wb_cti_o;
   logic [1:0]  wb_bte_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;
   logic        wb_rty_i;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   peripheral_burst_master_wb dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst_n),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_adr_i    (cmd_adr_i),
      .cmd_we_i     (cmd_we_i),
      .cmd_len_i    (cmd_len_i),
      .wdat_valid_i (wdat_valid_i),
      .wdat_i       (wdat_i),
      .wdat_ready_o (wdat_ready_o),
      .rdat_valid_o (rdat_valid_o),
      .rdat_o       (rdat_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .wb_adr_o     (wb_adr_o),
      .wb_dat_o     (wb_dat_o),
      .wb_sel_o     (wb_sel_o),
      .wb_we_o      (wb_we_o),
      .wb_cyc_o     (wb_cyc_o),
      .wb_stb_o     (wb_stb_o),
      .wb_cti_o     (wb_cti_o),
      .wb_bte_o     (wb_bte_o),
      .wb_dat_i     (wb_dat_i),
      .wb_ack_i     (wb_ack_i),
      .wb_err_i     (wb_err_i),
      .wb_rty_i     (wb_rty_i)
   );

   // ---------------- memory slave: 128 words, bytes 0x000..0x1FF ----------------
   logic [31:0] mem [128];
   bit          bfm_busy;
   int          bfm_wait;
   int unsigned bfm_max_delay = 0;
   int          rty_token = 0;
   int          rty_used = 0;
   logic [31:0] rty_adr = 32'h0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_ack_i <= 1'b0;
         wb_err_i <= 1'b0;
         wb_rty_i <= 1'b0;
         wb_dat_i <= 32'h0;
         bfm_busy <= 1'b0;
         bfm_wait <= 0;
      end else begin
         wb_ack_i <= 1'b0;
         wb_err_i <= 1'b0;
         wb_rty_i <= 1'b0;
         if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i && !wb_rty_i) begin
            if (!bfm_busy) begin
               bfm_busy <= 1'b1;
               bfm_wait <= int'($urandom_range(bfm_max_delay, 0));
            end else if (bfm_wait > 0) begin
               bfm_wait <= bfm_wait - 1;
            end else begin
               bfm_busy <= 1'b0;
               if (wb_adr_o >= 32'h200) begin
                  wb_err_i <= 1'b1;
               end else if (rty_token != rty_used && wb_adr_o == rty_adr) begin
                  wb_rty_i <= 1'b1;
                  rty_used <= rty_used + 1;
               end else begin
                  wb_ack_i <= 1'b1;
                  if (wb_we_o)
                     mem[wb_adr_o[8:2]] <= wb_dat_o;
                  else
                     wb_dat_i <= mem[wb_adr_o[8:2]];
               end
            end
         end else if (!wb_cyc_o) begin
            bfm_busy <= 1'b0;
         end
      end
   end

   // ---------------- bus monitor, sampled mid-cycle ----------------
   int          neg_cnt = 0;
   int          ack_total = 0;
   logic [31:0] ack_adr_log [256];
   logic [2:0]  ack_cti_log [256];
   logic [3:0]  ack_sel_log [256];
   logic        ack_we_log  [256];
   int          rd_total = 0;
   logic [31:0] rd_log [256];
   int          done_total = 0;
   int          err_total = 0;
   int          last_ack_cyc = 0;
   int          last_done_cyc = 0;
   int          srun = 0;
   int          run_total = 0;
   int          run_log [256];
   int          crun = 0;
   int          rise_total = 0;
   int          gap_log [256];

   always @(negedge clk) begin
      neg_cnt++;
      if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i && !wb_rty_i) begin
         ack_adr_log[ack_total % 256] = wb_adr_o;
         ack_cti_log[ack_total % 256] = wb_cti_o;
         ack_sel_log[ack_total % 256] = wb_sel_o;
         ack_we_log[ack_total % 256]  = wb_we_o;
         ack_total++;
         last_ack_cyc = neg_cnt;
      end
      if (rdat_valid_o) begin
         rd_log[rd_total % 256] = rdat_o;
         rd_total++;
      end
      if (done_o) begin
         done_total++;
         last_done_cyc = neg_cnt;
         if (err_o)
            err_total++;
      end
      // length of each stb-low stretch inside a held cycle
      if (wb_cyc_o && !wb_stb_o) begin
         srun++;
      end else if (wb_cyc_o && wb_stb_o && srun > 0) begin
         run_log[run_total % 256] = srun;
         run_total++;
         srun = 0;
      end else if (!wb_cyc_o) begin
         srun = 0;
      end
      // length of the cyc-low stretch preceding each cyc rise
      if (!wb_cyc_o) begin
         crun++;
      end else if (crun > 0) begin
         gap_log[rise_total % 256] = crun;
         rise_total++;
         crun = 0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue_cmd(input logic [31:0] adr, input logic we, input logic [3:0] len);
      @(posedge clk);
      #1;
      cmd_adr_i   = adr;
      cmd_we_i    = we;
      cmd_len_i   = len;
      cmd_valid_i = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL cmd_ready: got %0b expected 1 for adr %08h", cmd_ready_o, adr);
      end
      @(posedge clk);
      #1;
      cmd_valid_i = 1'b0;
      $display("cmd adr=%08h we=%0d len=%0d", adr, we, len);
   endtask

   task automatic drive_wdata(input logic [31:0] base, input int n, input int gap_at, input int gap_len);
      int w;
      for (int i = 0; i < n; i++) begin
         if (i == gap_at) begin
            wdat_valid_i = 1'b0;
            repeat (gap_len) @(posedge clk);
            #1;
         end
         wdat_i       = base + 32'(i);
         wdat_valid_i = 1'b1;
         w = 0;
         do begin
            @(negedge clk);
            w++;
         end while (wdat_ready_o !== 1'b1 && w < 300);
         if (wdat_ready_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wdat_timeout: word %0d never consumed, got ready %0b expected 1", i, wdat_ready_o);
         end
         @(posedge clk);
         #1;
      end
      wdat_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string name);
      int n = 0;
      while (done_total == d0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done_total == d0) begin
         errors++;
         $display("FAIL %s_timeout: got no done_o in %0d cycles, expected one", name, n);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wdat_ready_o} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_bus: got cyc/stb/we/wready %b expected 0000", {wb_cyc_o, wb_stb_o, wb_we_o, wdat_ready_o});
      end
      checks++;
      if ({wb_cti_o, wb_bte_o, wb_sel_o} !== 9'h000) begin
         errors++;
         $display("FAIL reset_cti: got cti/bte/sel %b expected all zero", {wb_cti_o, wb_bte_o, wb_sel_o});
      end
      checks++;
      if ({rdat_valid_o, done_o, err_o} !== 3'b000 || rdat_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_status: got rvalid/done/err %b rdat %08h expected 000 and 0", {rdat_valid_o, done_o, err_o}, rdat_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (cmd_ready_o !== 1'b1 || wb_cyc_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got ready %0b cyc %0b expected 1 0", cmd_ready_o, wb_cyc_o);
      end
   endtask

   task automatic test_write_burst();
      int a0 = ack_total;
      int d0 = done_total;
      int e0 = err_total;
      int r0 = run_total;
      fork
         drive_wdata(32'hA0, 4, -1, 0);
         begin
            issue_cmd(32'h100, 1'b1, 4'd3);
            wait_done(d0, "wr_burst");
         end
      join
      checks++;
      if (ack_total - a0 != 4) begin
         errors++;
         $display("FAIL wr_burst_acks: got %0d expected 4", ack_total - a0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (ack_adr_log[(a0 + i) % 256] !== 32'h100 + 32'(4 * i)) begin
            errors++;
            $display("FAIL wr_burst_adr%0d: got %08h expected %08h", i, ack_adr_log[(a0 + i) % 256], 32'h100 + 32'(4 * i));
         end
         checks++;
         if (ack_cti_log[(a0 + i) % 256] !== ((i == 3) ? 3'b111 : 3'b010)) begin
            errors++;
            $display("FAIL wr_burst_cti%0d: got %b expected %b", i, ack_cti_log[(a0 + i) % 256], (i == 3) ? 3'b111 : 3'b010);
         end
         checks++;
         if (ack_sel_log[(a0 + i) % 256] !== 4'hF || ack_we_log[(a0 + i) % 256] !== 1'b1) begin
            errors++;
            $display("FAIL wr_burst_selwe%0d: got sel %h we %0b expected f 1", i, ack_sel_log[(a0 + i) % 256], ack_we_log[(a0 + i) % 256]);
         end
         checks++;
         if (mem[64 + i] !== 32'hA0 + 32'(i)) begin
            errors++;
            $display("FAIL wr_burst_mem%0d: got %08h expected %08h", i, mem[64 + i], 32'hA0 + 32'(i));
         end
      end
      checks++;
      if (done_total - d0 != 1 || err_total != e0) begin
         errors++;
         $display("FAIL wr_burst_done: got done %0d err %0d expected 1 0", done_total - d0, err_total - e0);
      end
      // one register-load cycle between consecutive write beats
      checks++;
      if (run_total - r0 != 3 || run_log[r0 % 256] != 1 || run_log[(r0 + 1) % 256] != 1 || run_log[(r0 + 2) % 256] != 1) begin
         errors++;
         $display("FAIL wr_burst_gaps: got %0d stb-low runs expected 3 of length 1", run_total - r0);
      end
   endtask

   task automatic test_read_burst();
      int a0 = ack_total;
      int d0 = done_total;
      int e0 = err_total;
      int q0 = rd_total;
      bfm_max_delay = 4;
      issue_cmd(32'h100, 1'b0, 4'd3);
      wait_done(d0, "rd_burst");
      repeat (3) @(posedge clk);
      #1;
      bfm_max_delay = 0;
      checks++;
      if (rd_total - q0 != 4 || ack_total - a0 != 4) begin
         errors++;
         $display("FAIL rd_burst_pulses: got %0d rdat_valid %0d acks expected 4 4", rd_total - q0, ack_total - a0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rd_log[(q0 + i) % 256] !== 32'hA0 + 32'(i)) begin
            errors++;
            $display("FAIL rd_burst_data%0d: got %08h expected %08h", i, rd_log[(q0 + i) % 256], 32'hA0 + 32'(i));
         end
         checks++;
         if (ack_we_log[(a0 + i) % 256] !== 1'b0 || ack_cti_log[(a0 + i) % 256] !== ((i == 3) ? 3'b111 : 3'b010)) begin
            errors++;
            $display("FAIL rd_burst_ctl%0d: got we %0b cti %b", i, ack_we_log[(a0 + i) % 256], ack_cti_log[(a0 + i) % 256]);
         end
      end
      checks++;
      if (done_total - d0 != 1 || err_total != e0) begin
         errors++;
         $display("FAIL rd_burst_done: got done %0d err %0d expected 1 0", done_total - d0, err_total - e0);
      end
   endtask

   task automatic test_write_single();
      int a0 = ack_total;
      int d0 = done_total;
      fork
         drive_wdata(32'hC5, 1, -1, 0);
         begin
            issue_cmd(32'h180, 1'b1, 4'd0);
            wait_done(d0, "wr_single");
         end
      join
      checks++;
      if (ack_total - a0 != 1 || ack_cti_log[a0 % 256] !== 3'b000) begin
         errors++;
         $display("FAIL wr_single_cti: got %0d acks cti %b expected 1 000", ack_total - a0, ack_cti_log[a0 % 256]);
      end
      checks++;
      if (last_done_cyc - last_ack_cyc != 1) begin
         errors++;
         $display("FAIL wr_single_latency: got done %0d cycles after ack expected 1", last_done_cyc - last_ack_cyc);
      end
      checks++;
      if (mem[96] !== 32'hC5) begin
         errors++;
         $display("FAIL wr_single_mem: got %08h expected 000000c5", mem[96]);
      end
   endtask

   task automatic test_write_stall();
      int a0 = ack_total;
      int d0 = done_total;
      int r0 = run_total;
      int c0 = rise_total;
      fork
         drive_wdata(32'hD0, 4, 2, 3);
         begin
            issue_cmd(32'h1C0, 1'b1, 4'd3);
            wait_done(d0, "wr_stall");
         end
      join
      checks++;
      if (ack_total - a0 != 4 || rise_total - c0 != 1) begin
         errors++;
         $display("FAIL wr_stall_cyc: got %0d acks %0d cyc rises expected 4 1", ack_total - a0, rise_total - c0);
      end
      // 3 cycles without data plus the cycle that registers the late word
      checks++;
      if (run_total - r0 != 3 || run_log[r0 % 256] != 1 || run_log[(r0 + 1) % 256] != 4 || run_log[(r0 + 2) % 256] != 1) begin
         errors++;
         $display("FAIL wr_stall_stb: got runs %0d,%0d,%0d (count %0d) expected 1,4,1", run_log[r0 % 256], run_log[(r0 + 1) % 256], run_log[(r0 + 2) % 256], run_total - r0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[112 + i] !== 32'hD0 + 32'(i)) begin
            errors++;
            $display("FAIL wr_stall_mem%0d: got %08h expected %08h", i, mem[112 + i], 32'hD0 + 32'(i));
         end
      end
   endtask

   task automatic test_read_error();
      int a0 = ack_total;
      int d0 = done_total;
      int e0 = err_total;
      int q0 = rd_total;
      issue_cmd(32'h1000, 1'b0, 4'd2);
      wait_done(d0, "rd_err");
      checks++;
      if (done_total - d0 != 1 || err_total - e0 != 1) begin
         errors++;
         $display("FAIL rd_err_done: got done %0d err %0d expected 1 1", done_total - d0, err_total - e0);
      end
      checks++;
      if (rd_total != q0 || ack_total != a0) begin
         errors++;
         $display("FAIL rd_err_beats: got %0d rdat_valid %0d acks expected 0 0", rd_total - q0, ack_total - a0);
      end
      checks++;
      if (wb_cyc_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL rd_err_idle: got cyc %0b ready %0b expected 0 1", wb_cyc_o, cmd_ready_o);
      end
   endtask

   task automatic test_retry();
      int a0 = ack_total;
      int d0 = done_total;
      int e0 = err_total;
      int c0 = rise_total;
      rty_adr   = 32'h144;
      rty_token = rty_token + 1;
      fork
         drive_wdata(32'hB0, 4, -1, 0);
         begin
            issue_cmd(32'h140, 1'b1, 4'd3);
            wait_done(d0, "retry");
         end
      join
      checks++;
      if (rty_used != rty_token) begin
         errors++;
         $display("FAIL retry_issued: got %0d retries expected %0d", rty_used, rty_token);
      end
      checks++;
      if (ack_total - a0 != 4) begin
         errors++;
         $display("FAIL retry_acks: got %0d expected 4", ack_total - a0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (ack_adr_log[(a0 + i) % 256] !== 32'h140 + 32'(4 * i) || mem[80 + i] !== 32'hB0 + 32'(i)) begin
            errors++;
            $display("FAIL retry_beat%0d: got adr %08h mem %08h expected %08h %08h", i, ack_adr_log[(a0 + i) % 256], mem[80 + i], 32'h140 + 32'(4 * i), 32'hB0 + 32'(i));
         end
      end
      checks++;
      if (ack_cti_log[(a0 + 1) % 256] !== 3'b010) begin
         errors++;
         $display("FAIL retry_cti: got %b expected 010", ack_cti_log[(a0 + 1) % 256]);
      end
      checks++;
      if (rise_total - c0 != 2 || gap_log[(c0 + 1) % 256] != 1) begin
         errors++;
         $display("FAIL retry_gap: got %0d cyc rises, gap %0d expected 2 rises, gap 1", rise_total - c0, gap_log[(c0 + 1) % 256]);
      end
      checks++;
      if (done_total - d0 != 1 || err_total != e0) begin
         errors++;
         $display("FAIL retry_done: got done %0d err %0d expected 1 0", done_total - d0, err_total - e0);
      end
   endtask

   task automatic test_reset_mid_burst();
      int d0 = done_total;
      bfm_max_delay = 4;
      issue_cmd(32'h100, 1'b0, 4'd3);
      @(negedge clk);
      checks++;
      if (wb_cyc_o !== 1'b1) begin
         errors++;
         $display("FAIL midrst_active: got cyc %0b expected 1", wb_cyc_o);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
         errors++;
         $display("FAIL midrst_async: got cyc %0b stb %0b expected 0 0", wb_cyc_o, wb_stb_o);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      bfm_max_delay = 0;
      checks++;
      if (done_total != d0 || cmd_ready_o !== 1'b1 || wb_cyc_o !== 1'b0) begin
         errors++;
         $display("FAIL midrst_nodone: got done %0d ready %0b cyc %0b expected 0 1 0", done_total - d0, cmd_ready_o, wb_cyc_o);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      cmd_valid_i  = 1'b0;
      cmd_adr_i    = 32'h0;
      cmd_we_i     = 1'b0;
      cmd_len_i    = 4'd0;
      wdat_valid_i = 1'b0;
      wdat_i       = 32'h0;
      test_reset();
      test_write_burst();
      test_read_burst();
      test_write_single();
      test_write_stall();
      test_read_error();
      test_retry();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
